// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the shared datapath (slave).
interface mc_ctrl_if;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic [3:0]  dec_ALUOp;
    logic        mem_ready;

    logic        mem_req;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  NPCOp;
    logic        MemWrite;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUOp;
    logic [1:0]  WDSel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  Op, Funct, Zero, dec_ALUOp, mem_ready,
        output mem_req, IorD, IRWrite, PCWrite, NPCOp, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, WDSel, illegal, state, instret
    );

    modport slave (
        output Op, Funct, Zero, dec_ALUOp, mem_ready,
        input  mem_req, IorD, IRWrite, PCWrite, NPCOp, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, WDSel, illegal, state, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencer: IF/ID/EX/MEM/WB strobes with memory wait handshake.
// Optional retired-instruction counter built only when MC_CTRL_PERF_EN is defined.
//
// state | meaning
// IF    | fetch, hold mem_req until mem_ready, load IR and PC+4
// ID    | decode, branch target into ALUOut, trap illegal opcodes
// EX    | ALU op / address calc / branch and jump PC update
// MEM   | data access, hold mem_req (and MemWrite for stores) until mem_ready
// WB    | single-cycle register-file write
// HALT  | parked after an illegal opcode, left only through reset
module mc_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    mc_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic f_alu, f_jr, f_jalr;
    logic c_alui, c_load, c_store, c_beq, c_bne, c_j, c_jal;
    logic r_alu, r_jr, r_jalr, legal, br_taken;

    always_comb begin
        f_alu  = 1'b0;
        f_jr   = 1'b0;
        f_jalr = 1'b0;
        case (bus.Funct)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: f_alu = 1'b1;
            6'h08:   f_jr   = 1'b1;
            6'h09:   f_jalr = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        c_alui  = 1'b0;
        c_load  = 1'b0;
        c_store = 1'b0;
        c_beq   = 1'b0;
        c_bne   = 1'b0;
        c_j     = 1'b0;
        c_jal   = 1'b0;
        case (bus.Op)
            6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F: c_alui  = 1'b1;
            6'h23, 6'h21, 6'h25, 6'h20, 6'h24: c_load  = 1'b1;
            6'h2B, 6'h29, 6'h28:               c_store = 1'b1;
            6'h04:   c_beq = 1'b1;
            6'h05:   c_bne = 1'b1;
            6'h02:   c_j   = 1'b1;
            6'h03:   c_jal = 1'b1;
            default: ;
        endcase
    end

    assign r_alu    = (bus.Op == 6'h00) && f_alu;
    assign r_jr     = (bus.Op == 6'h00) && f_jr;
    assign r_jalr   = (bus.Op == 6'h00) && f_jalr;
    assign legal    = r_alu | r_jr | r_jalr | c_alui | c_load | c_store
                    | c_beq | c_bne | c_j | c_jal;
    assign br_taken = (c_beq & bus.Zero) | (c_bne & ~bus.Zero);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Everything is gated by rstn so strobes drop the instant reset asserts.
    always_comb begin
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.IorD     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.NPCOp    = 2'b00;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 4'b0000;
        bus.WDSel    = 2'b00;
        bus.illegal  = 1'b0;
        if (rstn) begin
            case (state_q)
                S_IF: begin
                    bus.mem_req = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 4'b0001;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_d     = S_ID;
                    end
                end
                S_ID: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ALUOp   = 4'b0001;
                    if (legal) begin
                        state_d = S_EX;
                    end else begin
                        bus.illegal = 1'b1;
                        state_d     = ILLEGAL_HALT ? S_HALT : S_IF;
                    end
                end
                S_EX: begin
                    bus.ALUSrcA = 1'b1;
                    if (r_alu) begin
                        bus.ALUOp = bus.dec_ALUOp;
                        state_d   = S_WB;
                    end else if (c_alui) begin
                        bus.ALUSrcB = 2'b10;
                        bus.ALUOp   = bus.dec_ALUOp;
                        state_d     = S_WB;
                    end else if (c_load | c_store) begin
                        bus.ALUSrcB = 2'b10;
                        bus.ALUOp   = 4'b0001;
                        state_d     = S_MEM;
                    end else if (c_beq | c_bne) begin
                        bus.ALUOp = 4'b0010;
                        if (br_taken) begin
                            bus.PCWrite = 1'b1;
                            bus.NPCOp   = 2'b01;
                        end
                        state_d = S_IF;
                    end else if (c_j | c_jal) begin
                        bus.PCWrite = 1'b1;
                        bus.NPCOp   = 2'b10;
                        state_d     = c_jal ? S_WB : S_IF;
                    end else begin
                        bus.PCWrite = 1'b1;
                        bus.NPCOp   = 2'b11;
                        state_d     = r_jalr ? S_WB : S_IF;
                    end
                end
                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemWrite = c_store;
                    if (bus.mem_ready) state_d = c_store ? S_IF : S_WB;
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.WDSel    = c_load ? 2'b01 : ((c_jal | r_jalr) ? 2'b10 : 2'b00);
                    state_d      = S_IF;
                end
                S_HALT: ;
                default: state_d = S_IF;
            endcase
        end
    end

    assign bus.state = state_q;

`ifdef MC_CTRL_PERF_EN
    // Illegal opcodes leave from ID, so only EX/MEM/WB exits count as retirements.
    logic        retire;
    logic [31:0] instret_q, instret_d;

    assign retire    = (state_q == S_EX || state_q == S_MEM || state_q == S_WB)
                    && (state_d == S_IF);
    assign instret_d = instret_q + 32'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       instret_q <= 32'd0;
        else if (retire) instret_q <= instret_d;
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction expected cycle traces built from instruction class.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       mr;
        logic       req;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] npc;
        logic       mw;
        logic       rw;
        logic       alu_chk;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic [1:0] wd;
        logic       ill;
    } cyc_t;

    localparam int K_RT = 0, K_ALUI = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8, K_ILL = 9;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk, rstn, rstn_h;
    mc_ctrl_if bus ();
    mc_ctrl_if bus_h ();

    mc_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));
    mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .rstn(rstn_h), .bus(bus_h));

    int          checks = 0;
    int          errors = 0;
    cyc_t        q[$];
    cyc_t        exp_c;
    logic        vld = 1'b0;
    logic [31:0] exp_ret = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic cyc_t mk(input logic [2:0] st, input logic mr);
        cyc_t c;
        c    = '0;
        c.st = st;
        c.mr = mr;
        return c;
    endfunction

    always @(negedge clk) begin
        if (vld) begin
            chk("state", {29'd0, bus.state}, {29'd0, exp_c.st});
            chk("mem_req", {31'd0, bus.mem_req}, {31'd0, exp_c.req});
            if (exp_c.req) chk("IorD", {31'd0, bus.IorD}, {31'd0, exp_c.iord});
            chk("IRWrite", {31'd0, bus.IRWrite}, {31'd0, exp_c.irw});
            chk("PCWrite", {31'd0, bus.PCWrite}, {31'd0, exp_c.pcw});
            if (exp_c.pcw) chk("NPCOp", {30'd0, bus.NPCOp}, {30'd0, exp_c.npc});
            chk("MemWrite", {31'd0, bus.MemWrite}, {31'd0, exp_c.mw});
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, exp_c.rw});
            chk("illegal", {31'd0, bus.illegal}, {31'd0, exp_c.ill});
            if (exp_c.alu_chk) begin
                chk("ALUSrcA", {31'd0, bus.ALUSrcA}, {31'd0, exp_c.asa});
                chk("ALUSrcB", {30'd0, bus.ALUSrcB}, {30'd0, exp_c.asb});
                chk("ALUOp", {28'd0, bus.ALUOp}, {28'd0, exp_c.aop});
            end
            if (exp_c.rw) chk("WDSel", {30'd0, bus.WDSel}, {30'd0, exp_c.wd});
        end
    end

    // Drives one record per cycle; with tail set, parks the DUT idle in IF afterwards.
    task automatic play(input bit tail);
        foreach (q[i]) begin
            @(posedge clk); #1;
            bus.mem_ready = q[i].mr;
            exp_c         = q[i];
            vld           = 1'b1;
        end
        if (tail) begin
            @(posedge clk); #1;
            vld           = 1'b0;
            bus.mem_ready = 1'b0;
            #3;
        end
    endtask

    task automatic push_front_end(input int if_w, input bit ill);
        cyc_t c;
        for (int i = 0; i < if_w; i++) begin
            c = mk(3'd0, 1'b0); c.req = 1'b1; c.alu_chk = 1'b1; c.asb = 2'b01; c.aop = 4'b0001;
            q.push_back(c);
        end
        c = mk(3'd0, 1'b1); c.req = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.npc = 2'b00;
        c.alu_chk = 1'b1; c.asb = 2'b01; c.aop = 4'b0001;
        q.push_back(c);
        c = mk(3'd1, 1'b0); c.alu_chk = 1'b1; c.asb = 2'b11; c.aop = 4'b0001; c.ill = ill;
        q.push_back(c);
    endtask

    task automatic run_instr(input string nm, input int kind, input logic [5:0] op,
                             input logic [5:0] fn, input logic [3:0] dalu, input logic z,
                             input int if_w, input int mem_w, input int exp_len);
        cyc_t c;
        q.delete();
        bus.Op = op; bus.Funct = fn; bus.dec_ALUOp = dalu; bus.Zero = z;
        push_front_end(if_w, kind == K_ILL);
        if (kind != K_ILL) begin
            c = mk(3'd2, 1'b0);
            case (kind)
                K_RT:       begin c.alu_chk = 1; c.asa = 1; c.asb = 2'b00; c.aop = dalu; end
                K_ALUI:     begin c.alu_chk = 1; c.asa = 1; c.asb = 2'b10; c.aop = dalu; end
                K_LD, K_ST: begin c.alu_chk = 1; c.asa = 1; c.asb = 2'b10; c.aop = 4'b0001; end
                K_BR: begin
                    c.alu_chk = 1; c.asa = 1; c.asb = 2'b00; c.aop = 4'b0010;
                    c.pcw = (op == 6'h04) ? z : ~z; c.npc = 2'b01;
                end
                K_J, K_JAL: begin c.pcw = 1; c.npc = 2'b10; end
                default:    begin c.pcw = 1; c.npc = 2'b11; end
            endcase
            q.push_back(c);
            if (kind == K_LD || kind == K_ST) begin
                for (int i = 0; i <= mem_w; i++) begin
                    c = mk(3'd3, i == mem_w); c.req = 1; c.iord = 1; c.mw = (kind == K_ST);
                    q.push_back(c);
                end
            end
            if (kind == K_RT || kind == K_ALUI || kind == K_LD || kind == K_JAL || kind == K_JALR) begin
                c = mk(3'd4, 1'b0); c.rw = 1;
                c.wd = (kind == K_LD) ? 2'b01 : ((kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00);
                q.push_back(c);
            end
            exp_ret++;
        end
        chk({nm, "_len"}, q.size(), exp_len);
        play(1'b1);
        chk({nm, "_end_state"}, {29'd0, bus.state}, 32'd0);
        chk({nm, "_instret"}, bus.instret, PERF ? exp_ret : 32'd0);
    endtask

    initial begin
        rstn = 1'b0; rstn_h = 1'b0;
        bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.dec_ALUOp = '0; bus.mem_ready = 1'b0;
        bus_h.Op = 6'h3F; bus_h.Funct = '0; bus_h.Zero = 1'b0; bus_h.dec_ALUOp = '0;
        bus_h.mem_ready = 1'b1;
        #12;
        chk("rst_state", {29'd0, bus.state}, 32'd0);
        chk("rst_strobes", {26'd0, bus.mem_req, bus.IRWrite, bus.PCWrite, bus.MemWrite,
                            bus.RegWrite, bus.illegal}, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        @(posedge clk); #1; rstn = 1'b1;
        #3;
        chk("first_fetch_req", {31'd0, bus.mem_req}, 32'd1);

        run_instr("add",    K_RT,   6'h00, 6'h20, 4'h5, 1'b0, 0, 0, 4);
        run_instr("lw",     K_LD,   6'h23, 6'h00, 4'h0, 1'b0, 2, 3, 10);
        run_instr("beq_t",  K_BR,   6'h04, 6'h00, 4'h0, 1'b1, 0, 0, 3);
        run_instr("beq_nt", K_BR,   6'h04, 6'h00, 4'h0, 1'b0, 0, 0, 3);
        run_instr("bne_t",  K_BR,   6'h05, 6'h00, 4'h0, 1'b0, 1, 0, 4);
        run_instr("sw",     K_ST,   6'h2B, 6'h00, 4'h0, 1'b0, 0, 1, 5);
        run_instr("ori",    K_ALUI, 6'h0D, 6'h00, 4'h3, 1'b0, 0, 0, 4);
        run_instr("lh",     K_LD,   6'h21, 6'h00, 4'h0, 1'b0, 0, 0, 5);
        run_instr("sb",     K_ST,   6'h28, 6'h00, 4'h0, 1'b0, 0, 0, 4);
        run_instr("j",      K_J,    6'h02, 6'h00, 4'h0, 1'b0, 0, 0, 3);
        run_instr("jal",    K_JAL,  6'h03, 6'h00, 4'h0, 1'b0, 0, 0, 4);
        run_instr("jr",     K_JR,   6'h00, 6'h08, 4'h0, 1'b0, 0, 0, 3);
        run_instr("jalr",   K_JALR, 6'h00, 6'h09, 4'h0, 1'b0, 0, 0, 4);
        run_instr("ill_op", K_ILL,  6'h3F, 6'h00, 4'h0, 1'b0, 0, 0, 2);
        run_instr("ill_fn", K_ILL,  6'h00, 6'h3F, 4'h0, 1'b0, 0, 0, 2);
        run_instr("sub",    K_RT,   6'h00, 6'h22, 4'hA, 1'b0, 0, 0, 4);

`ifdef MC_CTRL_PERF_EN
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_ret = 32'hFFFF_FFFE;
        run_instr("wrap1", K_RT, 6'h00, 6'h20, 4'h1, 1'b0, 0, 0, 4);
        chk("wrap_ffff", bus.instret, 32'hFFFF_FFFF);
        run_instr("wrap2", K_RT, 6'h00, 6'h20, 4'h1, 1'b0, 0, 0, 4);
        chk("wrap_zero", bus.instret, 32'd0);
`endif

        // sw interrupted by reset while waiting in MEM
        q.delete();
        bus.Op = 6'h2B; bus.Funct = '0;
        push_front_end(0, 1'b0);
        begin
            cyc_t c;
            c = mk(3'd2, 1'b0); c.alu_chk = 1; c.asa = 1; c.asb = 2'b10; c.aop = 4'b0001;
            q.push_back(c);
            c = mk(3'd3, 1'b0); c.req = 1; c.iord = 1; c.mw = 1;
            q.push_back(c);
            c = mk(3'd3, 1'b0); c.req = 1; c.iord = 1; c.mw = 1;
            q.push_back(c);
        end
        play(1'b0);
        @(negedge clk); #1;
        vld = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rstmem_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        chk("rstmem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rstmem_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rstmem_state", {29'd0, bus.state}, 32'd0);
        exp_ret = 32'd0;
        @(posedge clk); #1; rstn = 1'b1; bus.mem_ready = 1'b0;
        #3;
        chk("rstmem_refetch", {31'd0, bus.mem_req}, 32'd1);
        run_instr("after_rst", K_RT, 6'h00, 6'h25, 4'h7, 1'b0, 0, 0, 4);

        // halting instance: IF -> ID(illegal) -> HALT until reset
        @(posedge clk); #1; rstn_h = 1'b1;
        #3;
        chk("halt_if_state", {29'd0, bus_h.state}, 32'd0);
        @(posedge clk); #4;
        chk("halt_id_state", {29'd0, bus_h.state}, 32'd1);
        chk("halt_id_illegal", {31'd0, bus_h.illegal}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #4;
            chk("halt_state", {29'd0, bus_h.state}, 32'd7);
            chk("halt_strobes", {26'd0, bus_h.mem_req, bus_h.IRWrite, bus_h.PCWrite,
                                 bus_h.MemWrite, bus_h.RegWrite, bus_h.illegal}, 32'd0);
        end
        rstn_h = 1'b0;
        #1;
        chk("halt_rst_state", {29'd0, bus_h.state}, 32'd0);
        @(posedge clk); #1; rstn_h = 1'b1;
        #3;
        chk("halt_refetch", {31'd0, bus_h.mem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
